// File: rtl/recharge_select_pkg.sv
// Shared constants for the recharge/select front-end: state codes, wash modes, BCD width.
package recharge_select_pkg;

  localparam int unsigned BCD_W    = 12;
  localparam int unsigned DIGITS   = 3;
  localparam int unsigned STAGE_W  = 2;
  localparam int unsigned MODE_W   = 2;

  typedef enum logic [STAGE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_DEPOSIT = 2'd1,
    ST_SELECT  = 2'd2,
    ST_BUSY    = 2'd3
  } state_t;

  localparam logic [MODE_W-1:0] MODE_SPIN   = 2'd0;
  localparam logic [MODE_W-1:0] MODE_SMALL  = 2'd1;
  localparam logic [MODE_W-1:0] MODE_MEDIUM = 2'd2;
  localparam logic [MODE_W-1:0] MODE_LARGE  = 2'd3;

endpackage

// File: rtl/recharge_select_bcd3_addsub.sv
// Combinational 3-digit BCD add/subtract; add saturates at sat_max, subtract clamps at zero.
module bcd3_addsub
  import recharge_select_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             sub,
  input  logic [BCD_W-1:0] sat_max,
  output logic [BCD_W-1:0] y,
  output logic             borrow
);

  logic [BCD_W-1:0] raw;
  logic [4:0]       da;
  logic [4:0]       db;
  logic [4:0]       t;
  logic             c;

  // Ripple digit by digit, LSD first; c is carry when adding, borrow when subtracting.
  always_comb begin
    raw = '0;
    da  = '0;
    db  = '0;
    t   = '0;
    c   = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      da = {1'b0, a[4*i +: 4]};
      db = {1'b0, b[4*i +: 4]};
      if (sub) begin
        t = da - db - 5'(c);
        if (t[4]) begin
          t = t + 5'd10;
          c = 1'b1;
        end else begin
          c = 1'b0;
        end
      end else begin
        t = da + db + 5'(c);
        if (t > 5'd9) begin
          t = t + 5'd6;
          c = 1'b1;
        end else begin
          c = 1'b0;
        end
      end
      raw[4*i +: 4] = t[3:0];
    end
  end

  // Valid BCD orders the same as binary, so the ceiling check is a plain compare.
  always_comb begin
    borrow = sub & c;
    if (sub) begin
      y = c ? '0 : raw;
    end else begin
      y = (c || (raw > sat_max)) ? sat_max : raw;
    end
  end

endmodule

// File: rtl/recharge_select.sv
// Top-up / mode-select FSM feeding the billing stage, with idle timeout and next edge detect.
module recharge_select
  import recharge_select_pkg::*;
#(
  parameter logic [BCD_W-1:0] COIN_STEP   = 12'h010,
  parameter logic [BCD_W-1:0] BAL_MAX     = 12'h999,
  parameter int unsigned      TIMEOUT_CYC = 1_000_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m_pos,
  input  logic                u_pos,
  input  logic                d_pos,
  input  logic [BCD_W-1:0]    set0,
  input  logic [BCD_W-1:0]    set1,
  input  logic [BCD_W-1:0]    set2,
  input  logic [BCD_W-1:0]    set3,
  input  logic                next,
  output logic                on,
  output logic [BCD_W-1:0]    bal,
  output logic [MODE_W-1:0]   mode,
  output logic                err,
  output logic [STAGE_W-1:0]  stage
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t            state_q, state_d;
  logic [BCD_W-1:0]  bal_d;
  logic [MODE_W-1:0] mode_d;
  logic              err_d;
  logic [CNT_W-1:0]  idle_cnt, idle_cnt_d;
  logic              next_q;
  logic [BCD_W-1:0]  price;
  logic [BCD_W-1:0]  au_b;
  logic              au_sub;
  logic [BCD_W-1:0]  au_y;
  logic              au_borrow;
  logic              pulse;
  logic              timeout;
  logic              next_rise;

  // Price of the currently highlighted mode, sampled live.
  always_comb begin
    price = set0;
    case (mode)
      MODE_SPIN:   price = set0;
      MODE_SMALL:  price = set1;
      MODE_MEDIUM: price = set2;
      MODE_LARGE:  price = set3;
      default:     price = set0;
    endcase
  end

  // One arithmetic unit: coin step in DEPOSIT, bal - price borrow check in SELECT.
  assign au_b   = (state_q == ST_SELECT) ? price : COIN_STEP;
  assign au_sub = (state_q == ST_SELECT) | ~u_pos;

  bcd3_addsub u_addsub (
    .a       (bal),
    .b       (au_b),
    .sub     (au_sub),
    .sat_max (BAL_MAX),
    .y       (au_y),
    .borrow  (au_borrow)
  );

  assign pulse     = m_pos | u_pos | d_pos;
  assign timeout   = (idle_cnt == CNT_LAST);
  assign next_rise = next & ~next_q;
  assign stage     = state_q;

  // Next-state and next-output logic; button priority m > u > d.
  always_comb begin
    state_d = state_q;
    bal_d   = bal;
    mode_d  = mode;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        bal_d = '0;
        if (m_pos) state_d = ST_DEPOSIT;
      end
      ST_DEPOSIT: begin
        if (m_pos) begin
          state_d = ST_SELECT;
        end else if (u_pos || d_pos) begin
          bal_d = au_y;
        end else if (timeout) begin
          state_d = ST_IDLE;
          bal_d   = '0;
        end
      end
      ST_SELECT: begin
        if (m_pos) begin
          if (au_borrow) err_d = 1'b1;
          else           state_d = ST_BUSY;
        end else if (u_pos) begin
          mode_d = mode + 2'd1;
        end else if (d_pos) begin
          mode_d = mode - 2'd1;
        end else if (timeout) begin
          state_d = ST_IDLE;
          bal_d   = '0;
        end
      end
      ST_BUSY: begin
        if (next_rise) begin
          state_d = ST_IDLE;
          bal_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Idle counter runs only while waiting on the customer.
    if (pulse || (state_d != state_q)) begin
      idle_cnt_d = '0;
    end else if ((state_q == ST_DEPOSIT) || (state_q == ST_SELECT)) begin
      idle_cnt_d = idle_cnt + CNT_W'(1);
    end else begin
      idle_cnt_d = idle_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      bal      <= '0;
      mode     <= MODE_SPIN;
      err      <= 1'b0;
      on       <= 1'b0;
      idle_cnt <= '0;
      next_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bal      <= bal_d;
      mode     <= mode_d;
      err      <= err_d;
      on       <= (state_d == ST_BUSY);
      idle_cnt <= idle_cnt_d;
      next_q   <= next;
    end
  end

endmodule
